// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} rx_state_e;
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
  // Expected parity bit for up to 9 payload bits; unused upper bits must be zero.
  function automatic logic par_calc(input logic [8:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
endpackage

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: received-byte outputs handed to the rx CDC stage.
interface uart_rx_sampler_if #(parameter int DATA_BITS = 8);
  logic                 valid;
  logic [DATA_BITS-1:0] result;
  logic                 frame_err;
  logic                 parity_err;
  logic                 break_det;
  logic                 busy;
  modport master(output valid, result, frame_err, parity_err, break_det, busy);
  modport slave(input valid, result, frame_err, parity_err, break_det, busy);
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser with configurable reset value.
module uart_sync2 #(parameter logic RST_VAL = 1'b1) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m_q} <= {RST_VAL, RST_VAL};
    else     {q, m_q} <= {m_q, d};
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receiver with majority vote, parity,
// stop-bit and break detection.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic uart_clk,
  input  logic rst,
  input  logic rx,
  uart_rx_sampler_if.master rx_if
);
  localparam int MID = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  rx_state_e            st_q, st_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, res_q, res_d;
  logic [1:0]           smp_q, smp_d;
  logic                 pbit_q, pbit_d, mis_q, mis_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d, brk_q, brk_d;
  logic                 rx_s, dec, bit_v;
  uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(uart_clk), .rst(rst), .d(rx), .q(rx_s));
  // smp_q holds rx_s from the two cycles before, so at MID+1 it covers MID-1 and MID.
  assign smp_d = {smp_q[0], rx_s};
  assign dec   = scnt_q == SW'(MID + 1);
  assign bit_v = maj3({smp_q, rx_s});
  always_comb begin
    st_d    = st_q;
    scnt_d  = (scnt_q == SW'(OVERSAMPLE - 1)) ? '0 : scnt_q + 1'b1;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    res_d   = res_q;
    pbit_d  = pbit_q;
    mis_d   = mis_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    brk_d   = 1'b0;
    case (st_q)
      IDLE: begin
        scnt_d = rx_s ? '0 : SW'(1);
        st_d   = rx_s ? IDLE : START;
      end
      START: if (dec) begin
        st_d   = bit_v ? IDLE : DATA;
        bcnt_d = '0;
      end
      DATA: if (dec) begin
        sh_d   = {bit_v, sh_q[DATA_BITS-1:1]};
        bcnt_d = (bcnt_q == BW'(DATA_BITS - 1)) ? '0 : bcnt_q + 1'b1;
        st_d   = (bcnt_q != BW'(DATA_BITS - 1)) ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (dec) begin
        pbit_d = bit_v;
        mis_d  = bit_v != par_calc(9'(sh_q), PARITY_ODD != 0);
        st_d   = STOP;
      end
      STOP: if (dec) begin
        if (bit_v) begin
          if (bcnt_q == BW'(STOP_BITS - 1)) begin
            st_d    = IDLE;
            valid_d = 1'b1;
            res_d   = sh_q;
            perr_d  = mis_q;
          end else bcnt_d = bcnt_q + 1'b1;
        end else begin
          ferr_d = 1'b1;
          brk_d  = (sh_q == '0) && !pbit_q;
          st_d   = brk_d ? BREAK_WAIT : IDLE;
        end
      end
      BREAK_WAIT: st_d = rx_s ? IDLE : BREAK_WAIT;
      default:    st_d = IDLE;
    endcase
  end
  always_ff @(posedge uart_clk or posedge rst)
    if (rst) begin
      st_q    <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      smp_q   <= 2'b11;
      pbit_q  <= 1'b0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      smp_q   <= smp_d;
      pbit_q  <= pbit_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      brk_q   <= brk_d;
    end
  assign rx_if.valid      = valid_q;
  assign rx_if.result     = res_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.break_det  = brk_q;
  assign rx_if.busy       = st_q != IDLE;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: scoreboard bench for an 8N1 receiver and an 8E1 receiver.
module tb_uart_rx_sampler;
  logic uart_clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic rx_p = 1'b1;
  int total = 0;
  int bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_pq[$];
  logic [11:0] act_a, act_p, want_a, want_p;
  logic [7:0] last;
  int n;
  always #5 uart_clk = ~uart_clk;
  uart_rx_sampler_if #(.DATA_BITS(8)) bus();
  uart_rx_sampler_if #(.DATA_BITS(8)) bus_p();
  uart_rx_sampler #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0))
    dut (.uart_clk(uart_clk), .rst(rst), .rx(rx), .rx_if(bus));
  uart_rx_sampler #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0))
    dut_p (.uart_clk(uart_clk), .rst(rst), .rx(rx_p), .rx_if(bus_p));
  // Event record: {valid, result, parity_err, frame_err, break_det}
  always @(negedge uart_clk)
    if (!rst && (bus.valid || bus.frame_err || bus.break_det || bus.parity_err)) begin
      act_a = {bus.valid, bus.result, bus.parity_err, bus.frame_err, bus.break_det};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_8n1 unexpected event got=%h want=none", act_a);
      end else begin
        want_a = exp_q.pop_front();
        if (act_a !== want_a) begin
          bad++;
          $display("FAIL out_8n1 got=%h want=%h", act_a, want_a);
        end
      end
    end
  always @(negedge uart_clk)
    if (!rst && (bus_p.valid || bus_p.frame_err || bus_p.break_det || bus_p.parity_err)) begin
      act_p = {bus_p.valid, bus_p.result, bus_p.parity_err, bus_p.frame_err, bus_p.break_det};
      total++;
      if (exp_pq.size() == 0) begin
        bad++;
        $display("FAIL out_8e1 unexpected event got=%h want=none", act_p);
      end else begin
        want_p = exp_pq.pop_front();
        if (act_p !== want_p) begin
          bad++;
          $display("FAIL out_8e1 got=%h want=%h", act_p, want_p);
        end
      end
    end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask
  task automatic drv(input bit p, input logic v);
    if (p) rx_p = v;
    else rx = v;
  endtask
  task automatic send(input bit p, input logic [7:0] b, input int bt, input logic pb, input logic sb);
    drv(p, 1'b0);
    #(bt);
    for (int i = 0; i < 8; i++) begin
      drv(p, b[i]);
      #(bt);
    end
    if (p) begin
      drv(p, pb);
      #(bt);
    end
    drv(p, sb);
    #(bt);
    drv(p, 1'b1);
  endtask
  initial begin
    last = 8'h00;
    repeat (3) @(negedge uart_clk);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_frame_err", 32'(bus.frame_err), 0);
    chk("rst_parity_err", 32'(bus.parity_err), 0);
    chk("rst_break_det", 32'(bus.break_det), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge uart_clk);
    exp_q.push_back({1'b1, 8'hA5, 3'b000});
    last = 8'hA5;
    n = 0;
    fork
      send(0, 8'hA5, 160, 1'b0, 1'b1);
      while (!bus.valid && n < 400) begin
        @(negedge uart_clk);
        n++;
      end
    join
    chk("latency_a5", 32'(n), 156);
    repeat (40) @(negedge uart_clk);
    rx = 1'b0;
    repeat (3) @(negedge uart_clk);
    rx = 1'b1;
    repeat (3) @(negedge uart_clk);
    chk("glitch_busy_start", 32'(bus.busy), 1);
    repeat (14) @(negedge uart_clk);
    chk("glitch_busy_idle", 32'(bus.busy), 0);
    repeat (20) @(negedge uart_clk);
    exp_q.push_back({1'b0, last, 3'b010});
    send(0, 8'h3C, 160, 1'b0, 1'b0);
    repeat (40) @(negedge uart_clk);
    exp_q.push_back({1'b0, last, 3'b011});
    rx = 1'b0;
    #(160 * 20);
    rx = 1'b1;
    repeat (40) @(negedge uart_clk);
    exp_q.push_back({1'b1, 8'h55, 3'b000});
    last = 8'h55;
    send(0, 8'h55, 160, 1'b0, 1'b1);
    repeat (40) @(negedge uart_clk);
    exp_q.push_back({1'b1, 8'h00, 3'b000});
    exp_q.push_back({1'b1, 8'hFF, 3'b000});
    send(0, 8'h00, 165, 1'b0, 1'b1);
    send(0, 8'hFF, 155, 1'b0, 1'b1);
    last = 8'hFF;
    repeat (40) @(negedge uart_clk);
    rx = 1'b0;
    #(160 * 4);
    rx = 1'b1;
    rst = 1'b1;
    #30;
    rst = 1'b0;
    last = 8'h00;
    @(negedge uart_clk);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_result", 32'(bus.result), 0);
    repeat (40) @(negedge uart_clk);
    exp_q.push_back({1'b1, 8'hC3, 3'b000});
    send(0, 8'hC3, 160, 1'b0, 1'b1);
    repeat (40) @(negedge uart_clk);
    exp_pq.push_back({1'b1, 8'h03, 3'b100});
    send(1, 8'h03, 160, 1'b1, 1'b1);
    repeat (40) @(negedge uart_clk);
    exp_pq.push_back({1'b1, 8'h07, 3'b000});
    send(1, 8'h07, 160, 1'b1, 1'b1);
    repeat (200) @(negedge uart_clk);
    chk("pending_8n1", 32'(exp_q.size()), 0);
    chk("pending_8e1", 32'(exp_pq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
